// File: rtl/booth_multiplier_32.sv
// Sequential radix-2 Booth multiplier for signed two's-complement operands.
// One add/subtract/no-op of the multiplicand per clock; 2*WIDTH-bit product
// after WIDTH iterations, with a start/busy/done handshake.
// Optional feature: define MUL_OVF_FLAG_EN to add the ovf output, which flags
// products that do not fit in WIDTH signed bits.
module booth_multiplier_32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
`ifdef MUL_OVF_FLAG_EN
  ,
  output logic               ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state;
  logic [WIDTH-1:0]  m;
  logic [WIDTH:0]    a;      // one guard bit so M = -2^(WIDTH-1) cannot overflow
  logic [WIDTH-1:0]  q;
  logic              q_1;
  logic [CntW-1:0]   count;

  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     a_shift;
  logic [WIDTH-1:0]   q_shift;
  logic [2*WIDTH-1:0] prod_next;
  logic               last_iter;

  // One Booth step: recode {Q[0], q_1}, add/sub, then arithmetic shift right.
  always_comb begin
    m_ext = {m[WIDTH-1], m};
    case ({q[0], q_1})
      2'b01:   sum = a + m_ext;
      2'b10:   sum = a - m_ext;
      default: sum = a;
    endcase
    a_shift   = {sum[WIDTH], sum[WIDTH:1]};
    q_shift   = {sum[0], q[WIDTH-1:1]};
    prod_next = {a_shift[WIDTH-1:0], q_shift};
    last_iter = (count == CntW'(WIDTH - 1));
  end

`ifdef MUL_OVF_FLAG_EN
  logic [WIDTH:0] prod_top;
  logic           ovf_next;

  // Overflow when the upper WIDTH+1 product bits are not a pure sign extension.
  always_comb begin
    prod_top = prod_next[2*WIDTH-1:WIDTH-1];
    ovf_next = ~((&prod_top) | ~(|prod_top));
  end
`endif

  // Control FSM and datapath registers, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      m       <= '0;
      a       <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
`ifdef MUL_OVF_FLAG_EN
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            m     <= multiplicand;
            a     <= '0;
            q     <= multiplier;
            q_1   <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          a     <= a_shift;
          q     <= q_shift;
          q_1   <= q[0];
          count <= count + CntW'(1);
          if (last_iter) begin
            product <= prod_next;
`ifdef MUL_OVF_FLAG_EN
            ovf     <= ovf_next;
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= StDone;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier_32.sv
// Self-checking bench for booth_multiplier_32: a latency-level reference model
// (accept, then the signed product appears WIDTH+1 edges later) is compared
// with the DUT outputs after every clock edge, plus directed literal checks.
module tb_booth_multiplier_32;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  mc;
  logic [W-1:0]  mp;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;
`ifdef MUL_OVF_FLAG_EN
  logic          ovf;
`endif

  booth_multiplier_32 #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mc),
    .multiplier   (mp),
    .busy         (busy),
    .done         (done),
    .product      (product)
`ifdef MUL_OVF_FLAG_EN
    ,
    .ovf          (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_rem  = 0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_pend = '0;
`ifdef MUL_OVF_FLAG_EN
  bit          m_ovf  = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint r;
    r = longint'($signed(x)) * longint'($signed(y));
    return 64'(r);
  endfunction

`ifdef MUL_OVF_FLAG_EN
  function automatic bit ref_ovf(input logic [63:0] p);
    longint s;
    longint lim;
    s   = longint'(p);
    lim = longint'(1) <<< 31;
    return (s < -lim) || (s >= lim);
  endfunction
`endif

  // Model advances on each edge from the sampled inputs; compare 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_rem  = 0;
        m_prod = '0;
`ifdef MUL_OVF_FLAG_EN
        m_ovf  = 1'b0;
`endif
      end else begin
        m_done = 1'b0;
        if (m_busy) begin
          m_rem--;
          if (m_rem == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_prod = m_pend;
`ifdef MUL_OVF_FLAG_EN
            m_ovf  = ref_ovf(m_pend);
`endif
          end
        end else if (start) begin
          m_busy = 1'b1;
          m_rem  = W;
          m_pend = ref_mul(mc, mp);
        end
      end
      #1;
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("product", product, m_prod);
`ifdef MUL_OVF_FLAG_EN
      check("ovf", 64'(ovf), 64'(m_ovf));
`endif
    end
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Wait for done after the accept edge has already been counted in edges.
  task automatic wait_done(input string name, inout int edges);
    bit ok;
    ok = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done, expected done within 100 cycles", name);
    end
  endtask

  // Issue one operation from idle and wait for its completion.
  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                        output int edges);
    @(negedge clk);
    mc    = x;
    mp    = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    wait_done(name, edges);
    check({name, "_latency"}, 64'(edges), 64'(W + 1));
  endtask

  logic [31:0] corners [6];

  initial begin
    int e;
    int e2;
    int spurious;
    bit gap;
    logic [31:0] x;
    logic [31:0] y;

    corners = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h8000_0001};
    rst   = 1'b1;
    start = 1'b0;
    mc    = '0;
    mp    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
`ifdef MUL_OVF_FLAG_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // 1: 3 * -4
    run_op("t1", 32'd3, 32'hFFFF_FFFC, e);
    check("t1_product", product, 64'hFFFF_FFFF_FFFF_FFF4);
`ifdef MUL_OVF_FLAG_EN
    check("t1_ovf", 64'(ovf), 64'd0);
`endif

    // 2: most negative squared
    run_op("t2", 32'h8000_0000, 32'h8000_0000, e);
    check("t2_product", product, 64'h4000_0000_0000_0000);
`ifdef MUL_OVF_FLAG_EN
    check("t2_ovf", 64'(ovf), 64'd1);
`endif

    // 3: zero and -1 * -1, done is a single-cycle pulse
    run_op("t3a", 32'd0, 32'h7FFF_FFFF, e);
    check("t3a_product", product, 64'd0);
    @(posedge clk);
    #1;
    check("t3a_done_pulse", 64'(done), 64'd0);
    run_op("t3b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, e);
    check("t3b_product", product, 64'd1);
    @(posedge clk);
    #1;
    check("t3b_done_pulse", 64'(done), 64'd0);

    // 4: start re-pulsed mid-RUN is ignored
    @(negedge clk);
    mc = 32'd5;
    mp = 32'hFFFF_FFF9;
    start = 1'b1;
    @(posedge clk);
    #1;
    e = 1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    mc = 32'd99;
    mp = 32'd123;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gap = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (done) break;
      if (!busy) gap = 1'b1;
    end
    check("t4_product", product, 64'hFFFF_FFFF_FFFF_FFDD);
    check("t4_busy_gap", 64'(gap), 64'd0);
    repeat (3) @(posedge clk);

    // 5: reset at about iteration 10 aborts the operation
    @(negedge clk);
    mc = 32'd1234;
    mp = 32'd5678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) spurious++;
    end
    check("t5_no_done", 64'(spurious), 64'd0);
    run_op("t5b", 32'hFFFF_FFFD, 32'd11, e);
    check("t5b_product", product, 64'hFFFF_FFFF_FFFF_FFDF);

    // Simultaneous rst and start: rst wins
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    mc = 32'd3;
    mp = 32'd3;
    @(posedge clk);
    #1;
    check("rst_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("rst_start_idle", 64'(busy), 64'd0);

    // 6: start held high across DONE, back-to-back operations
    @(negedge clk);
    mc = 32'd7;
    mp = 32'd6;
    start = 1'b1;
    e = 0;
    wait_done("t6a", e);
    check("t6a_latency", 64'(e), 64'(W + 1));
    check("t6a_product", product, 64'd42);
    mc = 32'hFFFF_FFFB;
    mp = 32'd9;
    @(posedge clk);
    #1;
    e2 = 1;
    check("t6_busy_after_done", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done("t6b", e2);
    check("t6b_latency", 64'(e2), 64'(W + 1));
    check("t6b_product", product, 64'hFFFF_FFFF_FFFF_FFD3);

    // Randomized operations with corner-value bias and random idle gaps
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) x = corners[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) y = corners[$urandom_range(0, 5)];
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op("rand", x, y, e);
      check("rand_product", product, ref_mul(x, y));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
